// File: rtl/io_port_bank.sv
// Clocked GPIO port bank: per-port output latches, direction registers, 2-flop input sync, registered reads.
// Optional change-detect interrupt enabled by defining IO_PORT_IRQ_EN.
module io_port_bank #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PORTS      = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic                     RE,
    input  logic                     WE,
    input  logic [WIDTH-1:0]         Din,
    output logic [WIDTH-1:0]         Dout,
    output logic                     io_read,
    output logic                     io_write,
    input  logic [PORTS*WIDTH-1:0]   io_in,
    output logic [PORTS*WIDTH-1:0]   io_out,
    output logic [PORTS-1:0]         io_oe,
    output logic                     irq
);

    localparam int unsigned PIDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef logic [PORTS-1:0][WIDTH-1:0] bank_t;

    bank_t             latch_q, latch_d;
    bank_t             sync1_q, sync2_q;
    logic [PORTS-1:0]  oe_q, oe_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              read_q, read_d;
    logic              write_q, write_d;

    logic [32:0]       diff;
    logic [31:0]       off;
    logic              is_data, is_dir;
    logic [PIDX_W-1:0] sel;

    // Address decode; a borrow out of the subtraction means addr is below the base
    always_comb begin : decode
        diff    = 33'(addr) - 33'(BASE_ADDR);
        off     = diff[31:0];
        is_data = !diff[32] && (off < PORTS);
        is_dir  = !diff[32] && (off >= PORTS) && (off < 2 * PORTS);
        sel     = PIDX_W'(is_data ? off : off - PORTS);
    end

`ifdef IO_PORT_IRQ_EN
    bank_t             prev_q;
    logic [PORTS-1:0]  stat_q, stat_d, chg;
    logic              irq_q;
    logic              is_irq;

    // Change detect on input ports; a set in the same cycle as a clear wins
    always_comb begin : irq_next
        is_irq = !diff[32] && (off == 2 * PORTS);
        for (int unsigned p = 0; p < PORTS; p++) begin
            chg[p] = !oe_q[p] && (sync2_q[p] != prev_q[p]);
        end
        stat_d = stat_q & ~((WE && is_irq) ? PORTS'(Din) : '0);
        stat_d = stat_d | chg;
    end

    always_ff @(posedge clk or posedge rst) begin : irq_regs
        if (rst) begin
            prev_q <= '0;
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= sync2_q;
            stat_q <= stat_d;
            irq_q  <= |stat_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Access handling: a write takes priority over a simultaneous read
    always_comb begin : next_state
        latch_d = latch_q;
        oe_d    = oe_q;
        dout_d  = dout_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        if (WE) begin
            if (is_data) begin
                latch_d[sel] = Din;
                write_d      = 1'b1;
            end else if (is_dir) begin
                oe_d[sel] = Din[0];
                write_d   = 1'b1;
            end
`ifdef IO_PORT_IRQ_EN
            else if (is_irq) begin
                write_d = 1'b1;
            end
`endif
        end else if (RE) begin
            if (is_data) begin
                dout_d = oe_q[sel] ? latch_q[sel] : sync2_q[sel];
                read_d = 1'b1;
            end else if (is_dir) begin
                dout_d = WIDTH'(oe_q[sel]);
                read_d = 1'b1;
            end
`ifdef IO_PORT_IRQ_EN
            else if (is_irq) begin
                dout_d = WIDTH'(stat_q);
                read_d = 1'b1;
            end
`endif
            else begin
                dout_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : regs
        if (rst) begin
            latch_q <= '0;
            oe_q    <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            dout_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            latch_q <= latch_d;
            oe_q    <= oe_d;
            sync1_q <= io_in;
            sync2_q <= sync1_q;
            dout_q  <= dout_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    assign Dout     = dout_q;
    assign io_read  = read_q;
    assign io_write = write_q;
    assign io_out   = latch_q;
    assign io_oe    = oe_q;

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
Clocked, parametrised general-purpose I/O port bank on the CPU's 8-bit I/O address space. Successor to the combinational IO port decoder. Adds:
- registered per-port output latches and per-port direction registers;
- 2-flop input synchronisers;
- registered read data with a one-cycle read strobe.

The CPU drives addr/RE/WE/Din. Pin-side tri-stating is done at top level from io_out/io_oe.

Parameters:
WIDTH, 8, bits per port
PORTS, 8, number of ports (1..32)
ADDR_WIDTH, 8, address bus width
BASE_ADDR, 0, first decoded address; BASE_ADDR+2*PORTS+1 <= 2**ADDR_WIDTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
addr  in  ADDR_WIDTH  register address
RE  in  1  read request, sampled on clk
WE  in  1  write request, sampled on clk
Din  in  WIDTH  write data
Dout  out  WIDTH  registered read data
io_read  out  1  one-cycle pulse: Dout holds a decoded read
io_write  out  1  one-cycle pulse: a decoded write committed last edge
io_in  in  PORTS*WIDTH  raw pin inputs, port p at [p*WIDTH +: WIDTH], asynchronous
io_out  out  PORTS*WIDTH  output latches, same packing
io_oe  out  PORTS  per-port output enable, 1 = drive pins
irq  out  1  interrupt (IO_PORT_IRQ_EN only, else tied 0)

Behaviour:
- Register map, offset o = addr - BASE_ADDR:
  - o in [0, PORTS): DATA[p=o]
  - o in [PORTS, 2*PORTS): DIR[p=o-PORTS], bit 0 only
  - o = 2*PORTS: IRQ_STAT (feature only)
  - any other addr: unmapped
- Reset, asynchronous, all cleared:
  - output latches = 0, io_oe = 0 (all inputs)
  - sync flops = 0, Dout = 0, io_read = 0, io_write = 0, irq = 0, IRQ_STAT = 0
- Input sync: sync1 <= io_in, sync2 <= sync1 every cycle. Reads see sync2, so a pin change is visible 2 cycles later.
- Write (WE=1 at edge, mapped addr):
  - DATA[p] latch <= Din. The latch is written even if the port is an input; it takes effect when direction changes.
  - DIR[p]: io_oe[p] <= Din[0].
  - io_write = 1 for the next cycle.
  - Unmapped write: no state change, io_write stays 0.
- Read (RE=1, WE=0 at edge, mapped addr). Dout and io_read update at that edge, so data is valid in the following cycle (latency 1):
  - DATA[p]: Dout <= io_oe[p] ? latch[p] : sync2[p].
  - DIR[p]: Dout <= {WIDTH-1 zeros, io_oe[p]}.
  - io_read = 1 for that cycle.
  - Unmapped read: Dout <= 0, io_read = 0.
- RE=WE=1: the write is performed, the read is ignored, Dout holds, io_read = 0.
- No request: Dout holds its last value; io_read/io_write = 0.
- Back-to-back accesses every cycle are legal, with no wait states.
- Write DIR then read DATA on the next cycle: the read uses the new direction.
- Reset asserted mid-access: the access is aborted and all state returns to reset values immediately.

Optional Feature:
Macro: IO_PORT_IRQ_EN
- With the macro:
  - Per-port change detect on input ports: prev <= sync2 each cycle.
  - If io_oe[p]=0 and sync2[p] != prev[p], IRQ_STAT[p] <= 1.
  - IRQ_STAT is readable at offset 2*PORTS; bits >= PORTS read 0.
  - Writing IRQ_STAT clears the bits where Din is 1 (write-1-to-clear).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - irq = |IRQ_STAT, registered.
- Without the macro:
  - No prev or IRQ_STAT storage.
  - Offset 2*PORTS is unmapped.
  - irq is tied to 0.

Test Plan:
1. Reset then read all 2*PORTS addresses with io_in port p = p*p. Expect:
   - each DATA read returns p*p after the sync delay;
   - each DIR read returns 0;
   - io_read pulses once per read;
   - address 2*PORTS+1 returns 0 with io_read=0.
2. Write DIR[3]=1, then DATA[3]=8'hA5. Expect:
   - io_oe=8'b0000_1000;
   - io_out port3=8'hA5;
   - reading DATA[3] returns A5 while io_in port3=8'h09 (ignored);
   - io_write pulses twice.
3. Write DATA[2]=8'h3C while port 2 is an input, then set DIR[2]=1. Expect io_out port2=3C and io_oe[2]=1 one cycle after the DIR write.
4. Assert RE=WE=1 at DATA[0] with Din=8'h55. Expect:
   - latch0=55;
   - Dout unchanged from the prior read (e.g. 8'h00);
   - io_read=0, io_write=1.
5. Toggle io_in port5 from 8'h19 to 8'h1A mid-cycle. Expect a DATA[5] read to return 1A no earlier than 2 edges after the change. Assert rst during a write to DATA[1]: io_out port1 stays 0.
6. (IO_PORT_IRQ_EN) Change input port4. Expect:
   - IRQ_STAT=8'h10 and irq=1;
   - writing IRQ_STAT=8'h10 with a concurrent new port4 change leaves bit4 set;
   - a second clear with no change gives irq=0 the next cycle.
